// File: rtl/sfp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sfp_pkg : shared constants and FSM encoding for sfp_norm_array           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package sfp_pkg;

  localparam int SFP_COL     = 8;
  localparam int SFP_BW_PSUM = 20;
  localparam int SFP_BW_SUM  = 24;
  localparam int SFP_FRAC    = 8;

  // Rounding adds one guard quotient bit and resolves it half-up.
`ifdef SFP_NORM_ROUND_EN
  localparam int SFP_ROUND_EN = 1;
`else
  localparam int SFP_ROUND_EN = 0;
`endif

  typedef logic [1:0] sfp_state_t;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/sfp_seq_div.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sfp_seq_div : restoring divider, one quotient bit per cycle, MSB first   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module sfp_seq_div
  import sfp_pkg::*;
#(
  parameter int NW   = SFP_BW_PSUM,
  parameter int DW   = SFP_BW_SUM,
  parameter int FRAC = SFP_FRAC
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [NW-1:0] num,
  input  logic [DW-1:0] den,
  output logic [FRAC:0] q,
  output logic          dz,
  output logic          done
);

  localparam int NIT = FRAC + 1 + SFP_ROUND_EN;
  localparam int RW  = DW + 1;
  localparam int CW  = $clog2(NIT + 1);

  logic [RW-1:0]  rem_q, rem_d;
  logic [DW-1:0]  den_q, den_d;
  logic [NIT-1:0] quo_q, quo_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           dz_q, dz_d;
  logic           done_q, done_d;
  logic           rem_ge;

  // num never exceeds den (the sum includes |stored|), so rem stays below 2*den.
  always_comb begin
    rem_d  = rem_q;
    den_d  = den_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    dz_d   = dz_q;
    done_d = 1'b0;
    rem_ge = (rem_q >= {1'b0, den_q}) && !dz_q;
    if (start) begin
      rem_d = RW'(num);
      den_d = den;
      quo_d = '0;
      cnt_d = CW'(NIT);
      dz_d  = (den == '0);
    end else if (cnt_q != '0) begin
      if (rem_ge) begin
        quo_d = NIT'({quo_q, 1'b1});
        rem_d = (rem_q - {1'b0, den_q}) << 1;
      end else begin
        quo_d = NIT'({quo_q, 1'b0});
        rem_d = rem_q << 1;
      end
      cnt_d  = cnt_q - 1'b1;
      done_d = (cnt_q == CW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      den_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      dz_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      den_q  <= den_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      dz_q   <= dz_d;
      done_q <= done_d;
    end
  end

  generate
    if (SFP_ROUND_EN != 0) begin : g_round
      // Quotient is at most 2^(FRAC+1) with bit 0 clear, so the half-up add cannot overflow.
      assign q = dz_q ? '0 : (quo_q[NIT-1:1] + (FRAC+1)'(quo_q[0]));
    end else begin : g_trunc
      assign q = dz_q ? '0 : quo_q[FRAC:0];
    end
  endgenerate

  assign dz   = dz_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: rtl/sfp_norm_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sfp_norm_array : per-lane |psum| accumulation and serial normalisation   |
// | Optional macro SFP_NORM_ROUND_EN : half-up rounding, one extra DIV cycle |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module sfp_norm_array
  import sfp_pkg::*;
#(
  parameter int COL     = SFP_COL,
  parameter int BW_PSUM = SFP_BW_PSUM,
  parameter int BW_SUM  = SFP_BW_SUM,
  parameter int FRAC    = SFP_FRAC,
  localparam int LW     = (COL > 1) ? $clog2(COL) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   acc_valid,
  output logic                   acc_ready,
  input  logic [COL*BW_PSUM-1:0] acc_data,
  input  logic                   norm_start,
  input  logic                   clr,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BW_PSUM-1:0]     out_data,
  output logic [LW-1:0]          out_lane,
  output logic                   out_dz
);

  sfp_state_t                state_q, state_d;
  logic [LW-1:0]             lane_q, lane_d;
  logic                      out_valid_q, out_valid_d;
  logic [BW_PSUM-1:0]        out_data_q, out_data_d;
  logic [LW-1:0]             out_lane_q, out_lane_d;
  logic                      out_dz_q, out_dz_d;
  logic [BW_SUM-1:0]         sum_q [COL];
  logic [BW_SUM-1:0]         sum_d [COL];
  logic signed [BW_PSUM-1:0] stored_q [COL];
  logic signed [BW_PSUM-1:0] stored_d [COL];

  logic                      div_start, div_dz, div_done;
  logic [BW_PSUM-1:0]        div_num;
  logic [BW_SUM-1:0]         div_den;
  logic [FRAC:0]             div_q;
  logic [BW_PSUM-1:0]        q_ext;
  logic [BW_SUM:0]           acc_sum;

  // Two's-complement negate of the most negative value yields 2^(BW_PSUM-1) when read unsigned.
  function automatic logic [BW_PSUM-1:0] mag(input logic signed [BW_PSUM-1:0] x);
    return x[BW_PSUM-1] ? $unsigned(-x) : $unsigned(x);
  endfunction

  assign div_start = (state_q == ST_LOAD);
  assign div_num   = mag(stored_q[lane_q]);
  assign div_den   = sum_q[lane_q];
  assign q_ext     = {{(BW_PSUM-FRAC-1){1'b0}}, div_q};

  sfp_seq_div #(
    .NW   (BW_PSUM),
    .DW   (BW_SUM),
    .FRAC (FRAC)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .start (div_start),
    .num   (div_num),
    .den   (div_den),
    .q     (div_q),
    .dz    (div_dz),
    .done  (div_done)
  );

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_lane_d  = out_lane_q;
    out_dz_d    = out_dz_q;
    acc_sum     = '0;
    for (int i = 0; i < COL; i++) begin
      sum_d[i]    = sum_q[i];
      stored_d[i] = stored_q[i];
    end
    case (state_q)
      ST_IDLE: begin
        // clr beats a simultaneous beat; norm_start sees this cycle's beat.
        if (clr) begin
          for (int i = 0; i < COL; i++) begin
            sum_d[i]    = '0;
            stored_d[i] = '0;
          end
        end else if (acc_valid) begin
          for (int i = 0; i < COL; i++) begin
            acc_sum     = {1'b0, sum_q[i]}
                        + {{(BW_SUM+1-BW_PSUM){1'b0}}, mag(acc_data[i*BW_PSUM +: BW_PSUM])};
            sum_d[i]    = acc_sum[BW_SUM] ? '1 : acc_sum[BW_SUM-1:0];
            stored_d[i] = acc_data[i*BW_PSUM +: BW_PSUM];
          end
        end
        if (norm_start) begin
          state_d = ST_LOAD;
          lane_d  = '0;
        end
      end
      ST_LOAD: state_d = ST_DIV;
      ST_DIV: begin
        if (div_done) begin
          state_d     = ST_OUT;
          out_valid_d = 1'b1;
          out_data_d  = stored_q[lane_q][BW_PSUM-1] ? -q_ext : q_ext;
          out_lane_d  = lane_q;
          out_dz_d    = div_dz;
        end
      end
      ST_OUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (lane_q == LW'(COL-1)) begin
            state_d = ST_IDLE;
            for (int i = 0; i < COL; i++) begin
              sum_d[i]    = '0;
              stored_d[i] = '0;
            end
          end else begin
            lane_d  = lane_q + 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lane_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= '0;
      out_dz_q    <= 1'b0;
      for (int i = 0; i < COL; i++) begin
        sum_q[i]    <= '0;
        stored_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_lane_q  <= out_lane_d;
      out_dz_q    <= out_dz_d;
      for (int i = 0; i < COL; i++) begin
        sum_q[i]    <= sum_d[i];
        stored_q[i] <= stored_d[i];
      end
    end
  end

  assign acc_ready = (state_q == ST_IDLE) && !reset;
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_lane  = out_lane_q;
  assign out_dz    = out_dz_q;

endmodule
`default_nettype wire

// File: tb/tb_sfp_norm_array.sv
`default_nettype none
// tb_sfp_norm_array : randomized scenarios against an arithmetic reference of
// the accumulate / normalise behaviour.
module tb_sfp_norm_array;

  localparam int COL  = 8;
  localparam int BW   = 20;
  localparam int BS   = 24;
  localparam int FRAC = 8;
`ifdef SFP_NORM_ROUND_EN
  localparam int RND  = 1;
  localparam int EXP3 = 171;
`else
  localparam int RND  = 0;
  localparam int EXP3 = 170;
`endif
  localparam int     LAT = FRAC + 3 + RND;
  localparam longint SAT = (longint'(1) << BS) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              acc_valid = 1'b0;
  logic              norm_start = 1'b0;
  logic              clr = 1'b0;
  logic              out_ready = 1'b0;
  logic [COL*BW-1:0] acc_data = '0;
  logic              acc_ready, busy, out_valid, out_dz;
  logic [BW-1:0]     out_data;
  logic [2:0]        out_lane;

  int checks = 0;
  int errors = 0;

  longint        m_sum [COL];
  longint        m_st  [COL];
  int            bv    [COL];
  int            exp_d [COL];
  bit            exp_z [COL];
  int            cap_lat  [COL];
  logic [BW-1:0] cap_data [COL];
  logic [2:0]    cap_lane [COL];
  logic          cap_dz   [COL];
  bit            cap_to, cap_stable;

  sfp_norm_array #(.COL(COL), .BW_PSUM(BW), .BW_SUM(BS), .FRAC(FRAC)) dut (
    .clk        (clk),
    .reset      (reset),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .acc_data   (acc_data),
    .norm_start (norm_start),
    .clr        (clr),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_lane   (out_lane),
    .out_dz     (out_dz)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void model_clear();
    for (int i = 0; i < COL; i++) begin
      m_sum[i] = 0;
      m_st[i]  = 0;
    end
  endfunction

  function automatic void model_accept();
    for (int i = 0; i < COL; i++) begin
      longint a;
      a = (bv[i] < 0) ? -longint'(bv[i]) : longint'(bv[i]);
      m_sum[i] = (m_sum[i] + a > SAT) ? SAT : m_sum[i] + a;
      m_st[i]  = bv[i];
    end
  endfunction

  function automatic void model_expect();
    for (int i = 0; i < COL; i++) begin
      longint a, q;
      if (m_sum[i] == 0) begin
        exp_d[i] = 0;
        exp_z[i] = 1'b1;
      end else begin
        a = (m_st[i] < 0) ? -m_st[i] : m_st[i];
        if (RND != 0) q = ((a * (longint'(1) << (FRAC + 1))) / m_sum[i] + 1) / 2;
        else          q = (a * (longint'(1) << FRAC)) / m_sum[i];
        exp_d[i] = (m_st[i] < 0) ? -int'(q) : int'(q);
        exp_z[i] = 1'b0;
      end
    end
  endfunction

  function automatic int rand_val();
    int sel;
    sel = $urandom_range(0, 5);
    case (sel)
      0:       return -524288;
      1:       return 524287;
      2:       return int'($urandom_range(0, 20)) - 10;
      default: return int'($urandom_range(0, 1048575)) - 524288;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive_beat(input bit with_norm, input bit with_clr);
    for (int i = 0; i < COL; i++) acc_data[i*BW +: BW] = bv[i][BW-1:0];
    acc_valid  = 1'b1;
    norm_start = with_norm;
    clr        = with_clr;
    @(posedge clk); #1;
    acc_valid  = 1'b0;
    norm_start = 1'b0;
    clr        = 1'b0;
    if (with_clr) model_clear();
    else          model_accept();
  endtask

  task automatic start_norm();
    norm_start = 1'b1;
    @(posedge clk); #1;
    norm_start = 1'b0;
  endtask

  // Records each lane's output and the edge count since the previous reference edge.
  task automatic collect(input int stall_lane, input int stall_cyc, input int first_n, input int nlanes);
    int n;
    cap_to     = 1'b0;
    cap_stable = 1'b1;
    out_ready  = 1'b0;
    for (int i = 0; i < nlanes; i++) begin
      n = (i == 0) ? first_n : 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (out_valid !== 1'b1 && n < 100);
      if (out_valid !== 1'b1) begin
        cap_to = 1'b1;
        return;
      end
      cap_lat[i]  = n;
      cap_data[i] = out_data;
      cap_lane[i] = out_lane;
      cap_dz[i]   = out_dz;
      if (i == stall_lane) begin
        for (int k = 0; k < stall_cyc; k++) begin
          @(posedge clk); #1;
          if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== cap_data[i] ||
              out_lane !== cap_lane[i] || out_dz !== cap_dz[i]) cap_stable = 1'b0;
        end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({acc_ready, busy, out_valid, out_dz, out_lane, out_data} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got rdy=%b busy=%b vld=%b dz=%b lane=%0d data=%0d, want all 0",
                 k, acc_ready, busy, out_valid, out_dz, out_lane, out_data);
      end
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (acc_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got acc_ready=%b busy=%b, want 1 0", acc_ready, busy);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < COL; i++) bv[i] = 0;
    bv[0] = 10;  drive_beat(0, 0);
    bv[0] = -30; drive_beat(0, 0);
    model_expect();
    start_norm();
    collect(-1, 0, 0, COL);
    checks++;
    if (cap_to) begin
      errors++;
      $display("FAIL basic_timeout: out_valid never rose, want a result per lane");
    end else begin
      checks++;
      if ($signed(cap_data[0]) !== -20'sd192) begin
        errors++;
        $display("FAIL basic_lane0: got %0d, want -192", $signed(cap_data[0]));
      end
      for (int i = 0; i < COL; i++) begin
        checks++;
        if (cap_data[i] !== BW'(exp_d[i]) || cap_dz[i] !== exp_z[i] || cap_lane[i] !== 3'(i) || cap_lat[i] != LAT) begin
          errors++;
          $display("FAIL basic lane %0d: got data=%0d dz=%b lane=%0d lat=%0d, want data=%0d dz=%b lane=%0d lat=%0d",
                   i, $signed(cap_data[i]), cap_dz[i], cap_lane[i], cap_lat[i], exp_d[i], exp_z[i], i, LAT);
        end
      end
    end
    checks++;
    if (busy !== 1'b0 || acc_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_idle: got busy=%b acc_ready=%b, want 0 1", busy, acc_ready);
    end
    model_clear();
  endtask

  task automatic test_lane3();
    for (int i = 0; i < COL; i++) bv[i] = 0;
    bv[3] = 1; drive_beat(0, 0);
    bv[3] = 2; drive_beat(0, 0);
    start_norm();
    collect(-1, 0, 0, COL);
    checks++;
    if (cap_to || $signed(cap_data[3]) !== 20'(EXP3) || cap_dz[3] !== 1'b0) begin
      errors++;
      $display("FAIL lane3_value: got data=%0d dz=%b timeout=%b, want data=%0d dz=0",
               $signed(cap_data[3]), cap_dz[3], cap_to, EXP3);
    end
    model_clear();
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      int   nb;
      bit [7:0] zmask;
      nb    = $urandom_range(1, 4);
      zmask = 8'($urandom_range(0, 255));
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < COL; i++) bv[i] = zmask[i] ? 0 : rand_val();
        drive_beat((b == nb - 1) && r[0], 0);
      end
      model_expect();
      if (!r[0]) start_norm();
      collect(-1, 0, 0, COL);
      checks++;
      if (cap_to) begin
        errors++;
        $display("FAIL random_timeout round %0d: out_valid never rose", r);
      end else begin
        for (int i = 0; i < COL; i++) begin
          checks++;
          if (cap_data[i] !== BW'(exp_d[i]) || cap_dz[i] !== exp_z[i] || cap_lane[i] !== 3'(i) || cap_lat[i] != LAT) begin
            errors++;
            $display("FAIL random round %0d lane %0d: got data=%0d dz=%b lane=%0d lat=%0d, want data=%0d dz=%b lane=%0d lat=%0d",
                     r, i, $signed(cap_data[i]), cap_dz[i], cap_lane[i], cap_lat[i], exp_d[i], exp_z[i], i, LAT);
          end
        end
      end
      model_clear();
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < COL; i++) bv[i] = rand_val();
    drive_beat(0, 0);
    for (int i = 0; i < COL; i++) bv[i] = rand_val();
    drive_beat(0, 0);
    model_expect();
    start_norm();
    collect(2, 5, 0, COL);
    checks++;
    if (cap_to || !cap_stable) begin
      errors++;
      $display("FAIL stall_hold: got timeout=%b stable=%b, want timeout=0 stable=1", cap_to, cap_stable);
    end
    for (int i = 0; i < COL; i++) begin
      checks++;
      if (cap_data[i] !== BW'(exp_d[i]) || cap_dz[i] !== exp_z[i] || cap_lane[i] !== 3'(i) || cap_lat[i] != LAT) begin
        errors++;
        $display("FAIL stall lane %0d: got data=%0d dz=%b lane=%0d lat=%0d, want data=%0d dz=%b lane=%0d lat=%0d",
                 i, $signed(cap_data[i]), cap_dz[i], cap_lane[i], cap_lat[i], exp_d[i], exp_z[i], i, LAT);
      end
    end
    model_clear();
  endtask

  task automatic test_clr();
    for (int i = 0; i < COL; i++) bv[i] = rand_val();
    drive_beat(0, 0);
    for (int i = 0; i < COL; i++) bv[i] = rand_val();
    drive_beat(0, 1);
    for (int i = 0; i < COL; i++) bv[i] = (i % 3 == 0) ? 0 : rand_val();
    drive_beat(0, 0);
    model_expect();
    start_norm();
    clr = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr = 1'b0;
    collect(-1, 0, 2, COL);
    checks++;
    if (cap_to) begin
      errors++;
      $display("FAIL clr_timeout: out_valid never rose");
    end
    for (int i = 0; i < COL; i++) begin
      checks++;
      if (cap_data[i] !== BW'(exp_d[i]) || cap_dz[i] !== exp_z[i] || cap_lat[i] != LAT) begin
        errors++;
        $display("FAIL clr lane %0d: got data=%0d dz=%b lat=%0d, want data=%0d dz=%b lat=%0d",
                 i, $signed(cap_data[i]), cap_dz[i], cap_lat[i], exp_d[i], exp_z[i], LAT);
      end
    end
    model_clear();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < COL; i++) bv[i] = 0;
    bv[5] = -524288;
    for (int b = 0; b < 1000; b++) drive_beat(0, 0);
    model_expect();
    start_norm();
    acc_valid = 1'b1;
    acc_data  = {COL{20'h7FFFF}};
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (acc_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_reject cycle %0d: got acc_ready=%b busy=%b, want 0 1", k, acc_ready, busy);
      end
    end
    acc_valid = 1'b0;
    collect(-1, 0, 3, COL);
    checks++;
    if (cap_to) begin
      errors++;
      $display("FAIL saturate_timeout: out_valid never rose");
    end
    for (int i = 0; i < COL; i++) begin
      checks++;
      if (cap_data[i] !== BW'(exp_d[i]) || cap_dz[i] !== exp_z[i] || cap_lat[i] != LAT) begin
        errors++;
        $display("FAIL saturate lane %0d: got data=%0d dz=%b lat=%0d, want data=%0d dz=%b lat=%0d",
                 i, $signed(cap_data[i]), cap_dz[i], cap_lat[i], exp_d[i], exp_z[i], LAT);
      end
    end
    model_clear();
  endtask

  task automatic test_reset_abort();
    int nv;
    for (int i = 0; i < COL; i++) bv[i] = int'($urandom_range(1, 1000));
    drive_beat(0, 0);
    start_norm();
    collect(-1, 0, 0, 4);
    repeat (4) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({acc_ready, busy, out_valid, out_dz, out_lane, out_data} !== '0) begin
      errors++;
      $display("FAIL abort_reset_outputs: got rdy=%b busy=%b vld=%b dz=%b lane=%0d data=%0d, want all 0",
               acc_ready, busy, out_valid, out_dz, out_lane, out_data);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    nv = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) nv++;
    end
    checks++;
    if (nv != 0 || acc_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_quiet: got %0d out_valid cycles acc_ready=%b, want 0 and 1", nv, acc_ready);
    end
    model_expect();
    start_norm();
    collect(-1, 0, 0, COL);
    checks++;
    if (cap_to) begin
      errors++;
      $display("FAIL abort_timeout: out_valid never rose after restart");
    end
    for (int i = 0; i < COL; i++) begin
      checks++;
      if (cap_data[i] !== BW'(exp_d[i]) || cap_dz[i] !== exp_z[i] || cap_lane[i] !== 3'(i)) begin
        errors++;
        $display("FAIL abort lane %0d: got data=%0d dz=%b lane=%0d, want data=%0d dz=%b lane=%0d",
                 i, $signed(cap_data[i]), cap_dz[i], cap_lane[i], exp_d[i], exp_z[i], i);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_lane3();
    test_random();
    test_stall();
    test_clr();
    test_saturate();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
